text_overlay_gen: RTL

TEXT_OVERLAY_GEN -- requirements
Module: text_overlay_gen

---
 rtl/text_overlay_gen.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/text_overlay_gen.sv
// Text overlay generator: renders a fixed string of 5x7 glyphs at a
// programmable position and scale. Characters can appear one by one
// (typewriter) and/or blink. Animation state only moves on frame_start,
// trigger or a mode change, so a frame is never drawn with mixed state.
module text_overlay_gen #(
  parameter int          TEXT_X0       = 249,
  parameter int          TEXT_Y0       = 325,
  parameter int          SCALE_LOG2    = 1,
  parameter int          NUM_CHARS     = 12,
  parameter logic [63:0] MSG           = 64'h0000_9840_7765_4321,
  parameter logic [5:0]  COLOR         = 6'b110110,
  parameter logic [5:0]  TRANSPARENT   = 6'b100001,
  parameter int          REVEAL_FRAMES = 8,
  parameter int          BLINK_FRAMES  = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       active,
  input  logic       frame_start,
  input  logic [1:0] mode,
  input  logic       trigger,
  output logic [5:0] rgb,
  output logic       done
);

  localparam int S        = 1 << SCALE_LOG2;
  localparam int PITCH    = 6 * S;
  localparam int GLYPH_W  = 5 * S;
  localparam int REGION_W = NUM_CHARS * PITCH - S;
  localparam int REGION_H = 7 * S;

  localparam logic [4:0] NUM5    = 5'(NUM_CHARS);
  localparam logic [7:0] RF_LAST = 8'(REVEAL_FRAMES - 1);
  localparam logic [7:0] BF_LAST = 8'(BLINK_FRAMES - 1);

  // Glyph bitmaps, row 0 in the top 5 bits, MSB of each row is the leftmost pixel.
  localparam logic [34:0] G_W = {5'b10001, 5'b10001, 5'b10001, 5'b10101, 5'b10101, 5'b11011, 5'b10001};
  localparam logic [34:0] G_A = {5'b01110, 5'b10001, 5'b10001, 5'b11111, 5'b10001, 5'b10001, 5'b10001};
  localparam logic [34:0] G_T = {5'b11111, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100};
  localparam logic [34:0] G_E = {5'b11111, 5'b10000, 5'b10000, 5'b11110, 5'b10000, 5'b10000, 5'b11111};
  localparam logic [34:0] G_R = {5'b11110, 5'b10001, 5'b10001, 5'b11110, 5'b10100, 5'b10010, 5'b10001};
  localparam logic [34:0] G_L = {5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b11111};
  localparam logic [34:0] G_O = {5'b01110, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b01110};
  localparam logic [34:0] G_N = {5'b10001, 5'b11001, 5'b10101, 5'b10101, 5'b10011, 5'b10001, 5'b10001};
  localparam logic [34:0] G_G = {5'b01110, 5'b10001, 5'b10000, 5'b10111, 5'b10001, 5'b10001, 5'b01110};

  function automatic logic [34:0] glyph(input logic [3:0] code);
    case (code)
      4'd1:    glyph = G_W;
      4'd2:    glyph = G_A;
      4'd3:    glyph = G_T;
      4'd4:    glyph = G_E;
      4'd5:    glyph = G_R;
      4'd6:    glyph = G_L;
      4'd7:    glyph = G_O;
      4'd8:    glyph = G_N;
      4'd9:    glyph = G_G;
      default: glyph = 35'd0;  // space and unused codes
    endcase
  endfunction

  typedef enum logic [1:0] {ST_REVEAL, ST_HOLD, ST_BLINK} state_t;

  state_t      r_state;
  logic [7:0]  r_frame_cnt;
  logic [4:0]  r_revealed;
  logic        r_visible;
  logic [1:0]  r_mode;
  logic [5:0]  r_rgb;

  logic [9:0]  w_rel_x;
  logic [9:0]  w_rel_y;
  logic [9:0]  w_col;
  logic [3:0]  w_char;
  logic [3:0]  w_code;
  logic [2:0]  w_gcol;
  logic [2:0]  w_grow;
  logic [34:0] w_glyph;
  logic [4:0]  w_row_bits;
  logic        w_bit;
  logic        w_in_region;
  logic        w_lit;
  logic        w_restart;

  // x left of TEXT_X0 wraps to a large offset and falls outside the region.
  assign w_rel_x     = x - 10'(TEXT_X0);
  assign w_rel_y     = y - 10'(TEXT_Y0);
  assign w_in_region = (w_rel_x < 10'(REGION_W)) && (w_rel_y < 10'(REGION_H));

  // Character cell lookup by comparison against constant cell boundaries
  // (avoids a divider); the last boundary passed gives the index and offset.
  always_comb begin
    w_char = '0;
    w_col  = w_rel_x;
    for (int i = 1; i < NUM_CHARS; i++) begin
      if (w_rel_x >= 10'(i * PITCH)) begin
        w_char = 4'(i);
        w_col  = w_rel_x - 10'(i * PITCH);
      end
    end
  end

  // Glyph bit fetch and lit decision for the current pixel.
  always_comb begin
    w_code     = MSG[4*w_char +: 4];
    w_glyph    = glyph(w_code);
    w_gcol     = 3'(w_col >> SCALE_LOG2);
    w_grow     = 3'(w_rel_y >> SCALE_LOG2);
    w_row_bits = (w_grow < 3'd7) ? w_glyph[34 - 5*w_grow -: 5] : 5'd0;
    w_bit      = (w_gcol < 3'd5) ? w_row_bits[3'd4 - w_gcol] : 1'b0;
    w_lit      = active && w_in_region && (w_col < 10'(GLYPH_W)) && w_bit &&
                 ({1'b0, w_char} < r_revealed) && r_visible;
  end

  // Registered colour output, one cycle behind the pixel coordinates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rgb <= TRANSPARENT;
    else        r_rgb <= w_lit ? COLOR : TRANSPARENT;
  end

  // A trigger or any mode change restarts the animation; it wins over frame_start.
  assign w_restart = trigger || (mode != r_mode);

  // Animation FSM: reveal counter, blink phase, and the restart/forcing rules.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_REVEAL;
      r_frame_cnt <= '0;
      r_revealed  <= '0;
      r_visible   <= 1'b1;
      r_mode      <= 2'd0;
    end else begin
      r_mode <= mode;
      if (w_restart) begin
        r_frame_cnt <= '0;
        r_visible   <= 1'b1;
        case (mode)
          2'd0:    begin r_revealed <= NUM5; r_state <= ST_HOLD;   end
          2'd2:    begin r_revealed <= NUM5; r_state <= ST_BLINK;  end
          default: begin r_revealed <= '0;   r_state <= ST_REVEAL; end
        endcase
      end else if (mode == 2'd0) begin
        // Static mode holds the full string on screen, including straight out of reset.
        r_revealed <= NUM5;
        r_visible  <= 1'b1;
        r_state    <= ST_HOLD;
      end else begin
        if (mode == 2'd2) begin
          r_revealed <= NUM5;
          r_state    <= ST_BLINK;
        end
        if (frame_start) begin
          case (r_state)
            ST_REVEAL: begin
              if (r_frame_cnt == RF_LAST) begin
                r_frame_cnt <= '0;
                if (r_revealed < NUM5) r_revealed <= r_revealed + 5'd1;
                if (r_revealed >= NUM5 - 5'd1) begin
                  r_state <= (mode == 2'd3) ? ST_BLINK : ST_HOLD;
                end
              end else begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
              end
            end
            ST_BLINK: begin
              if (r_frame_cnt == BF_LAST) begin
                r_frame_cnt <= '0;
                r_visible   <= ~r_visible;
              end else begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
              end
            end
            default: ;  // hold: nothing moves
          endcase
        end
      end
    end
  end

  assign rgb  = r_rgb;
  assign done = (r_revealed == NUM5);

endmodule
